// File: rtl/pcie_timer_pkg.sv
// ============================================================================
//  Module      : pcie_timer_pkg
//  Description : Shared constants and helpers for the LTSSM timer bank.
//                These are the interval codes, the Gen codes, the Gen1 base
//                tick counts, the channel state encoding and the PIPE-width
//                shift helper.
//                Optional macro PCIE_TIMER_FAST_SIM_EN divides each nonzero
//                base count by 1024, with a floor of 1, to give short
//                simulation timeouts.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pcie_timer_pkg;

  // Interval codes
  localparam logic [2:0] T0MS   = 3'b000;
  localparam logic [2:0] T12MS  = 3'b001;
  localparam logic [2:0] T24MS  = 3'b010;
  localparam logic [2:0] T48MS  = 3'b011;
  localparam logic [2:0] T2MS   = 3'b100;
  localparam logic [2:0] T8MS   = 3'b101;
  localparam logic [2:0] T1MS   = 3'b110;
  localparam logic [2:0] T100US = 3'b111;

  // Rate codes
  localparam logic [2:0] GEN1 = 3'b001;
  localparam logic [2:0] GEN2 = 3'b010;
  localparam logic [2:0] GEN3 = 3'b011;
  localparam logic [2:0] GEN4 = 3'b100;
  localparam logic [2:0] GEN5 = 3'b101;

  // Gen1 base counts in 32-bit-PIPE Pclk cycles (62.5 MHz); 22 bits hold the largest
  localparam int              c_base_w      = 22;
  localparam logic [21:0]     c_base_t0ms   = 22'd0;
  localparam logic [21:0]     c_base_t12ms  = 22'd750000;
  localparam logic [21:0]     c_base_t24ms  = 22'd1500000;
  localparam logic [21:0]     c_base_t48ms  = 22'd3000000;
  localparam logic [21:0]     c_base_t2ms   = 22'd125000;
  localparam logic [21:0]     c_base_t8ms   = 22'd500000;
  localparam logic [21:0]     c_base_t1ms   = 22'd62500;
  localparam logic [21:0]     c_base_t100us = 22'd6250;

  // Channel state encoding
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  // Narrower PIPE data paths run Pclk faster, so they need more ticks
  function automatic logic [1:0] width_shift(input int pipewidth);
    case (pipewidth)
      32:      return 2'd0;
      16:      return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // Base count for an interval code, optionally shortened for simulation
  function automatic logic [c_base_w-1:0] base_count(input logic [2:0] code);
    logic [c_base_w-1:0] b;
    case (code)
      T0MS:    b = c_base_t0ms;
      T12MS:   b = c_base_t12ms;
      T24MS:   b = c_base_t24ms;
      T48MS:   b = c_base_t48ms;
      T2MS:    b = c_base_t2ms;
      T8MS:    b = c_base_t8ms;
      T1MS:    b = c_base_t1ms;
      default: b = c_base_t100us;
    endcase
`ifdef PCIE_TIMER_FAST_SIM_EN
    if (b != '0) begin
      b = b >> 10;
      if (b == '0) b = {{(c_base_w-1){1'b0}}, 1'b1};
    end
`else
    b = b;
`endif
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcie_timer_channel.sv
// ============================================================================
//  Module      : pcie_timer_channel
//  Description : One LTSSM timeout channel. It is an IDLE/RUN/DONE FSM with a
//                tick counter. The interval is scaled by rate and PIPE width,
//                saturated to CNT_WIDTH, and latched at Start.
//                Honours PCIE_TIMER_FAST_SIM_EN through pcie_timer_pkg.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pcie_timer_channel
  import pcie_timer_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 8,
  parameter int GEN3_PIPEWIDTH = 8,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic [2:0] Gen,
  input  logic       Enable,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Periodic,
  input  logic [2:0] IntervalCode,
  output logic       Running,
  output logic       TimeOut,
  output logic       Expired
);

  // At least 30 bits, so that a 22-bit base shifted left by up to 6 never loses bits
  localparam int CALC_W = (CNT_WIDTH + 8 > 30) ? (CNT_WIDTH + 8) : 30;

  localparam logic [1:0] c_ws_gen1 = width_shift(GEN1_PIPEWIDTH);
  localparam logic [1:0] c_ws_gen2 = width_shift(GEN2_PIPEWIDTH);
  localparam logic [1:0] c_ws_gen3 = width_shift(GEN3_PIPEWIDTH);
  localparam logic [1:0] c_ws_gen4 = width_shift(GEN4_PIPEWIDTH);
  localparam logic [1:0] c_ws_gen5 = width_shift(GEN5_PIPEWIDTH);
  localparam logic [CNT_WIDTH-1:0] c_tick_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_tick;
  logic [CNT_WIDTH-1:0] r_interval;
  logic [CNT_WIDTH-1:0] w_interval;
  logic                 r_periodic;
  logic                 r_timeout;
  logic                 r_expired;
  logic [2:0]           w_gen_shift;
  logic [1:0]           w_width_shift;
  logic [2:0]           w_shift;
  logic [c_base_w-1:0]  w_base;
  logic [CALC_W-1:0]    w_scaled;
  logic                 w_sat;
  logic                 w_hit;

  // Map the current rate onto its generation and PIPE-width shift amounts (unknown codes act as Gen1)
  always_comb begin
    w_gen_shift   = 3'd0;
    w_width_shift = c_ws_gen1;
    case (Gen)
      GEN2:    begin w_gen_shift = 3'd1; w_width_shift = c_ws_gen2; end
      GEN3:    begin w_gen_shift = 3'd2; w_width_shift = c_ws_gen3; end
      GEN4:    begin w_gen_shift = 3'd3; w_width_shift = c_ws_gen4; end
      GEN5:    begin w_gen_shift = 3'd4; w_width_shift = c_ws_gen5; end
      default: ;
    endcase
  end

  // Scale the base count in a wide datapath, then clamp it to the counter width
  always_comb begin
    w_base     = base_count(IntervalCode);
    w_shift    = w_gen_shift + {1'b0, w_width_shift};
    w_scaled   = {{(CALC_W-c_base_w){1'b0}}, w_base} << w_shift;
    w_sat      = |w_scaled[CALC_W-1:CNT_WIDTH];
    w_interval = w_sat ? {CNT_WIDTH{1'b1}} : w_scaled[CNT_WIDTH-1:0];
  end

  // The comparison does not depend on Enable, so a zero interval expires after one cycle
  assign w_hit = (r_state == c_st_run) && (r_tick >= r_interval);

  // State register
  always_ff @(posedge Pclk or posedge Reset) begin
    if (Reset) r_state <= c_st_idle;
    else       r_state <= w_state_nxt;
  end

  // Next state: Start beats Stop; a hit retires one-shot channels to DONE
  always_comb begin
    w_state_nxt = r_state;
    if (Start)      w_state_nxt = c_st_run;
    else if (Stop)  w_state_nxt = c_st_idle;
    else if (w_hit) w_state_nxt = r_periodic ? c_st_run : c_st_done;
  end

  // Tick counter, latched interval and mode, and registered expiry flags
  always_ff @(posedge Pclk or posedge Reset) begin
    if (Reset) begin
      r_tick     <= '0;
      r_interval <= '0;
      r_periodic <= 1'b0;
      r_timeout  <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (Start) begin
        r_tick     <= '0;
        r_interval <= w_interval;
        r_periodic <= Periodic;
        r_timeout  <= 1'b0;
      end else if (Stop) begin
        r_tick    <= '0;
        r_timeout <= 1'b0;
      end else if (r_state == c_st_run) begin
        if (w_hit) begin
          r_expired <= 1'b1;
          r_timeout <= 1'b1;
          if (r_periodic) r_tick <= '0;
        end else begin
          r_timeout <= 1'b0;
          if (Enable) r_tick <= r_tick + c_tick_one;
        end
      end
    end
  end

  // Outputs decoded from flops only
  always_comb begin
    Running = (r_state == c_st_run);
    TimeOut = r_timeout;
    Expired = r_expired;
  end

endmodule

`default_nettype wire

// File: rtl/pcie_timer_bank.sv
// ============================================================================
//  Module      : pcie_timer_bank
//  Description : A bank of NUM_TIMERS independent LTSSM timeout channels that
//                share Pclk, Reset, Gen and Enable.
//                Optional macro PCIE_TIMER_FAST_SIM_EN selects shortened base
//                counts for simulation.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pcie_timer_bank
  import pcie_timer_pkg::*;
#(
  parameter int NUM_TIMERS     = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 8,
  parameter int GEN3_PIPEWIDTH = 8,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input  logic                    Pclk,
  input  logic                    Reset,
  input  logic [2:0]              Gen,
  input  logic                    Enable,
  input  logic [NUM_TIMERS-1:0]   Start,
  input  logic [NUM_TIMERS-1:0]   Stop,
  input  logic [NUM_TIMERS-1:0]   Periodic,
  input  logic [3*NUM_TIMERS-1:0] IntervalCode,
  output logic [NUM_TIMERS-1:0]   Running,
  output logic [NUM_TIMERS-1:0]   TimeOut,
  output logic [NUM_TIMERS-1:0]   Expired
);

  // One channel per timer; each takes its own slice of the per-channel buses
  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
    pcie_timer_channel #(
      .CNT_WIDTH      (CNT_WIDTH),
      .GEN1_PIPEWIDTH (GEN1_PIPEWIDTH),
      .GEN2_PIPEWIDTH (GEN2_PIPEWIDTH),
      .GEN3_PIPEWIDTH (GEN3_PIPEWIDTH),
      .GEN4_PIPEWIDTH (GEN4_PIPEWIDTH),
      .GEN5_PIPEWIDTH (GEN5_PIPEWIDTH)
    ) u_chan (
      .Pclk         (Pclk),
      .Reset        (Reset),
      .Gen          (Gen),
      .Enable       (Enable),
      .Start        (Start[i]),
      .Stop         (Stop[i]),
      .Periodic     (Periodic[i]),
      .IntervalCode (IntervalCode[3*i +: 3]),
      .Running      (Running[i]),
      .TimeOut      (TimeOut[i]),
      .Expired      (Expired[i])
    );
  end

endmodule

`default_nettype wire
